// File: rtl/systolic_mm_array.sv
// Output-stationary ROWS x COLS systolic matrix-multiply array with input skew,
// tile controller and valid/ready streaming on both sides.
module systolic_mm_array #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 36,
  parameter int unsigned K_MAX  = 256,
  localparam int unsigned KW    = $clog2(K_MAX + 1),
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     accumulate,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   act_in,
  input  logic [COLS*DATA_W-1:0]   wgt_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RW-1:0]            out_row,
  output logic [COLS*ACC_W-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned FW = $clog2(ROWS + COLS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [KW-1:0] remain, remain_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic [RW-1:0] row_nxt;
  logic          valid_nxt, last_nxt, done_nxt;
  logic          load_c, clear_c, adv_c, flush_c;
  logic [COLS*ACC_W-1:0] row_data_c;

  logic signed [DATA_W-1:0]   a_edge [ROWS];
  logic signed [DATA_W-1:0]   w_edge [COLS];
  logic signed [DATA_W-1:0]   a_op   [ROWS][COLS];
  logic signed [DATA_W-1:0]   w_op   [ROWS][COLS];
  logic signed [DATA_W-1:0]   a_q    [ROWS][COLS];
  logic signed [DATA_W-1:0]   w_q    [ROWS][COLS];
  logic signed [2*DATA_W-1:0] prod   [ROWS][COLS];
  logic [ACC_W-1:0]           acc    [ROWS][COLS];

  assign flush_c = (state == S_FLUSH);
  assign adv_c   = (in_ready & in_valid) | flush_c;

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      remain <= '0;
      fcnt   <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      fcnt   <= fcnt_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    fcnt_nxt   = fcnt;
    row_nxt    = out_row;
    valid_nxt  = out_valid;
    last_nxt   = out_last;
    done_nxt   = 1'b0;
    load_c     = 1'b0;
    clear_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          remain_nxt = k_len;
          fcnt_nxt   = '0;
          clear_c    = ~accumulate;
          if (k_len != '0) begin
            state_nxt = S_COMPUTE;
          end else begin
            state_nxt = S_DRAIN;
            valid_nxt = 1'b1;
            row_nxt   = '0;
            last_nxt  = (ROWS == 1);
            load_c    = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (in_valid && in_ready) begin
          remain_nxt = remain - KW'(1);
          if (remain == KW'(1)) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        fcnt_nxt = fcnt + FW'(1);
        if (fcnt == FW'(ROWS + COLS - 2)) begin
          fcnt_nxt  = '0;
          state_nxt = S_DRAIN;
          valid_nxt = 1'b1;
          row_nxt   = '0;
          last_nxt  = (ROWS == 1);
          load_c    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            state_nxt = S_IDLE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            row_nxt  = out_row + RW'(1);
            last_nxt = (row_nxt == RW'(ROWS - 1));
            load_c   = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row selected for the next out_data load
  always_comb begin
    row_data_c = '0;
    for (int j = 0; j < COLS; j++) row_data_c[j*ACC_W +: ACC_W] = acc[row_nxt][j];
  end

  // Registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == S_COMPUTE);
      busy      <= (state_nxt != S_IDLE);
      out_valid <= valid_nxt;
      out_row   <= row_nxt;
      out_last  <= last_nxt;
      done      <= done_nxt;
      if (load_c) out_data <= clear_c ? '0 : row_data_c;
    end
  end

  // Activation skew: lane i delayed by i advances, zero operands during flush
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    logic signed [DATA_W-1:0] lane;
    assign lane = flush_c ? '0 : $signed(act_in[i*DATA_W +: DATA_W]);
    if (i == 0) begin : g_direct
      assign a_edge[i] = lane;
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr [i];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else if (adv_c) begin
          sr[0] <= lane;
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end
      assign a_edge[i] = sr[i-1];
    end
  end

  // Weight skew: lane j delayed by j advances
  for (genvar j = 0; j < COLS; j++) begin : g_wskew
    logic signed [DATA_W-1:0] lane;
    assign lane = flush_c ? '0 : $signed(wgt_in[j*DATA_W +: DATA_W]);
    if (j == 0) begin : g_direct
      assign w_edge[j] = lane;
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr [j];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else if (adv_c) begin
          sr[0] <= lane;
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end
      assign w_edge[j] = sr[j-1];
    end
  end

  // PE operand routing: activations enter from the left, weights from the top
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j == 0) begin : g_aedge
        assign a_op[i][j] = a_edge[i];
      end else begin : g_ainner
        assign a_op[i][j] = a_q[i][j-1];
      end
      if (i == 0) begin : g_wedge
        assign w_op[i][j] = w_edge[j];
      end else begin : g_winner
        assign w_op[i][j] = w_q[i-1][j];
      end
      assign prod[i][j] = a_op[i][j] * w_op[i][j];
    end
  end

  // PE forwarding registers and wrapping accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= '0;
          w_q[i][j] <= '0;
          acc[i][j] <= '0;
        end
      end
    end else if (clear_c) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
      end
    end else if (adv_c) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= a_op[i][j];
          w_q[i][j] <= w_op[i][j];
          acc[i][j] <= acc[i][j] + ACC_W'(prod[i][j]);
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_array.sv
// Bench for systolic_mm_array: directed and random tiles on an 8x8 array plus a
// 4x6 narrow-width instance, checked against a sum-of-products reference.
module tb_systolic_mm_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8x8, 16-bit data, 36-bit sums
  logic         start, accumulate, in_valid, in_ready;
  logic [8:0]   k_len;
  logic [127:0] act_in, wgt_in;
  logic         out_valid, out_ready, out_last, busy, done;
  logic [2:0]   out_row;
  logic [287:0] out_data;

  // 4x6, 8-bit data, 20-bit sums
  logic         s_start, s_accumulate, s_in_valid, s_in_ready;
  logic [4:0]   s_k_len;
  logic [31:0]  s_act;
  logic [47:0]  s_wgt;
  logic         s_out_valid, s_out_ready, s_out_last, s_busy, s_done;
  logic [1:0]   s_out_row;
  logic [119:0] s_out_data;

  systolic_mm_array #(.ROWS(8), .COLS(8), .DATA_W(16), .ACC_W(36), .K_MAX(256)) u_big (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .accumulate(accumulate),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wgt_in(wgt_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  systolic_mm_array #(.ROWS(4), .COLS(6), .DATA_W(8), .ACC_W(20), .K_MAX(16)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .k_len(s_k_len), .accumulate(s_accumulate),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .act_in(s_act), .wgt_in(s_wgt),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_row(s_out_row), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy), .done(s_done)
  );

  int     total = 0;
  int     bad   = 0;
  int     a_st [16][8];
  int     w_st [16][8];
  longint c_ref [8][8];
  int     sw [4][6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_row"},   64'(out_row),   64'd0);
    chk({tag, "_data_nz"},   64'(|out_data), 64'd0);
    chk({tag, "_out_last"},  64'(out_last),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
  endtask

  task automatic fill_identity();
    for (int n = 0; n < 8; n++)
      for (int l = 0; l < 8; l++) begin
        a_st[n][l] = (l == n) ? 1 : 0;
        w_st[n][l] = 8 * n + l + 1;
      end
  endtask

  task automatic fill_const(input int a, input int w);
    for (int l = 0; l < 8; l++) begin
      a_st[0][l] = a;
      w_st[0][l] = w;
    end
  endtask

  // bub: 0 full rate, 1 pattern 1,0,0,..., 2 random. stall_row -2 = random out_ready.
  task automatic run_tile(input int k, input bit accm, input int bub, input int stall_row,
                          input bit glitch, input int exp_first, input int exp_done,
                          input string tag);
    int n, row, stall, tcyc, t_first;
    logic [287:0] exp_row;
    if (!accm)
      for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) c_ref[i][j] = 0;
    for (int v = 0; v < k; v++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          c_ref[i][j] += longint'(a_st[v][i]) * longint'(w_st[v][j]);
    start = 1'b1; k_len = 9'(k); accumulate = accm; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tcyc = 1; n = 0; row = 0; stall = 0; t_first = -1;
    chk({tag, "_busy_c1"}, 64'(busy), 64'd1);
    while (row < 8 && tcyc < 3000) begin
      start = glitch && (tcyc == 3);
      if (start) begin
        k_len = 9'd3;
        accumulate = ~accm;
      end
      in_valid = 1'b0;
      if (n < k) begin
        case (bub)
          0:       in_valid = 1'b1;
          1:       in_valid = (tcyc % 3 == 1);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        for (int l = 0; l < 8; l++) begin
          act_in[l*16 +: 16] = 16'(a_st[n][l]);
          wgt_in[l*16 +: 16] = 16'(w_st[n][l]);
        end
      end
      if (in_valid && in_ready) n++;
      if (stall_row == -2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(out_valid && row == stall_row && stall < 3);
      if (out_valid) begin
        if (t_first < 0) t_first = tcyc;
        for (int j = 0; j < 8; j++) exp_row[j*36 +: 36] = 36'(c_ref[row][j]);
        total++;
        assert (out_data === exp_row) else begin
          bad++;
          $error("FAIL %s_data row=%0d observed=%h expected=%h", tag, row, out_data, exp_row);
        end
        chk({tag, "_row"},  64'(out_row),  64'(row));
        chk({tag, "_last"}, 64'(out_last), 64'(row == 7));
        if (out_ready) row++;
        else stall++;
      end
      @(posedge clk); #1;
      tcyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    chk({tag, "_rows_done"}, 64'(row), 64'd8);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    if (exp_first >= 0) chk({tag, "_first_cyc"}, 64'(t_first), 64'(exp_first));
    if (exp_done >= 0)  chk({tag, "_done_cyc"},  64'(tcyc),    64'(exp_done));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int tc, nn, rr, ff;
    logic [119:0] s_exp;
    int sum;

    rst = 1'b1; start = 1'b0; k_len = '0; accumulate = 1'b0; in_valid = 1'b0;
    act_in = '0; wgt_in = '0; out_ready = 1'b0;
    s_start = 1'b0; s_k_len = '0; s_accumulate = 1'b0; s_in_valid = 1'b0;
    s_act = '0; s_wgt = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of COMPUTE, then accumulate on top of the cleared sums
    fill_identity();
    start = 1'b1; k_len = 9'd8; accumulate = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1;
      for (int l = 0; l < 8; l++) begin
        act_in[l*16 +: 16] = 16'(a_st[v][l]);
        wgt_in[l*16 +: 16] = 16'(w_st[v][l]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) c_ref[i][j] = 0;
    fill_const(1, 1);
    run_tile(1, 1'b1, 0, -1, 1'b0, 17, 25, "rst_acc");

    // Identity load at full rate
    fill_identity();
    run_tile(8, 1'b0, 0, -1, 1'b0, 24, 32, "ident");

    // Signed extremes
    fill_const(-32768, -32768);
    run_tile(1, 1'b0, 0, -1, 1'b0, 17, 25, "neg_sq");
    fill_const(-1, 32767);
    run_tile(1, 1'b0, 0, -1, 1'b0, 17, 25, "neg_mix");

    // Input bubbles and output backpressure at row 2
    fill_identity();
    run_tile(8, 1'b0, 1, 2, 1'b0, -1, -1, "bubble");

    // Accumulate across tiles, start ignored mid-tile, then an empty clearing tile
    run_tile(8, 1'b1, 0, -1, 1'b0, 24, 32, "accum");
    run_tile(8, 1'b0, 0, -1, 1'b1, 24, 32, "glitch");
    run_tile(0, 1'b0, 0, -1, 1'b0, 1, 9, "k0");

    // Random tiles with random bubbles and random backpressure
    for (int t = 0; t < 3; t++) begin
      nn = int'($urandom_range(1, 12));
      for (int v = 0; v < nn; v++)
        for (int l = 0; l < 8; l++) begin
          a_st[v][l] = int'($urandom_range(0, 65535)) - 32768;
          w_st[v][l] = int'($urandom_range(0, 65535)) - 32768;
        end
      run_tile(nn, 1'($urandom_range(0, 1)), 2, -2, 1'b0, -1, -1, "rand");
    end

    // Narrow 4x6 instance: identity activations pick out weight vector i for row i
    for (int v = 0; v < 4; v++)
      for (int j = 0; j < 6; j++) sw[v][j] = int'($urandom_range(0, 255)) - 128;
    s_start = 1'b1; s_k_len = 5'd4; s_accumulate = 1'b0;
    @(posedge clk); #1;
    s_start = 1'b0; tc = 1; nn = 0; rr = 0; ff = -1;
    while (rr < 4 && tc < 500) begin
      s_in_valid = (nn < 4);
      if (nn < 4) begin
        for (int l = 0; l < 4; l++) s_act[l*8 +: 8] = (l == nn) ? 8'd1 : 8'd0;
        for (int j = 0; j < 6; j++) s_wgt[j*8 +: 8] = 8'(sw[nn][j]);
      end
      if (s_in_valid && s_in_ready) nn++;
      if (s_out_valid) begin
        if (ff < 0) ff = tc;
        for (int j = 0; j < 6; j++) begin
          sum = 0;
          for (int v = 0; v < 4; v++) sum += ((rr == v) ? 1 : 0) * sw[v][j];
          s_exp[j*20 +: 20] = 20'(sum);
        end
        total++;
        assert (s_out_data === s_exp) else begin
          bad++;
          $error("FAIL small_data row=%0d observed=%h expected=%h", rr, s_out_data, s_exp);
        end
        chk("small_row", 64'(s_out_row), 64'(rr));
        chk("small_last", 64'(s_out_last), 64'(rr == 3));
        rr++;
      end
      @(posedge clk); #1;
      tc++;
    end
    s_in_valid = 1'b0;
    chk("small_rows_done", 64'(rr), 64'd4);
    chk("small_first_cyc", 64'(ff), 64'd14);
    chk("small_done_cyc", 64'(tc), 64'd18);
    chk("small_done", 64'(s_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_mm_array.md
# systolic_mm_array

Parametrised output-stationary systolic matrix-multiply array, the successor of the fixed 8x8 PE cluster. It is generalised to ROWS x COLS PEs and configurable data and accumulator widths. It adds internal input skewing, a tile controller with valid/ready streaming on input and output, and an optional accumulate-across-tiles mode. It sits between the activation/weight buffers and the attention score/softmax stage, and produces C[i][j] = sum over n of a[n]_i * w[n]_j for one tile.

## Interface
- ROWS, 8, PE rows (activation lanes), >= 1
- COLS, 8, PE columns (weight lanes), >= 1
- DATA_W, 16, signed activation/weight width
- ACC_W, 36, signed accumulator width, >= 2*DATA_W
- K_MAX, 256, maximum vectors per tile; KW = $clog2(K_MAX+1)
- clk  in  1  clock; one clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin tile; honoured only in IDLE
- k_len  in  KW  vectors in tile, sampled on accepted start
- accumulate  in  1  sampled on accepted start; 1 = keep previous sums, 0 = clear
- in_valid  in  1  input vector valid
- in_ready  out  1  array accepts vector
- act_in  in  ROWS*DATA_W  activation vector, lane i at [i*DATA_W +: DATA_W]
- wgt_in  in  COLS*DATA_W  weight vector, lane j at [j*DATA_W +: DATA_W]
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts row
- out_row  out  $clog2(ROWS) (min 1)  row index of out_data
- out_data  out  COLS*ACC_W  sums of row out_row, column j at [j*ACC_W +: ACC_W]
- out_last  out  1  marks row ROWS-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last row is accepted

## Operation
- FSM states are IDLE, COMPUTE, FLUSH, DRAIN.
- IDLE, start=1:
  - Latch k_len; clear all sums if accumulate=0; reset the accept counter.
  - Next state is COMPUTE if k_len>0, otherwise DRAIN.
- COMPUTE:
  - in_ready=1; an accept occurs when in_valid and in_ready are both 1.
  - On the accept of vector k_len-1, go to FLUSH.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles and feeds zero operands into the skew inputs.
  - Then go to DRAIN.
- DRAIN:
  - Present rows 0..ROWS-1 in order, one row per handshake.
  - After row ROWS-1 is accepted, go to IDLE and pulse done.
- Array advance ("adv") is (COMPUTE and accept) or FLUSH. All skew, inter-PE and accumulator registers update only on adv, so in_valid bubbles never inject data.
- Skew:
  - Activation lane i passes through i delay registers; weight lane j passes through j.
  - Activations move right one PE per adv; weights move down one PE per adv.
  - PE(i,j) adds the products of vector n at advance n+i+j+1, counting advances from the first accept.
- Arithmetic:
  - Signed DATA_W x DATA_W product, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- Sums persist after DRAIN until the next start with accumulate=0, or until rst.
- start outside IDLE is ignored; k_len and accumulate are not resampled.
- k_len > K_MAX is undefined usage; the bench never drives it.

## Timing
- Reset values: in_ready=0, out_valid=0, out_row=0, out_data=0, out_last=0, busy=0, done=0. All sums and pipeline registers are 0 and the state is IDLE.
- rst in any state, including mid-COMPUTE or mid-DRAIN, aborts the tile. The next cycle shows reset values; partial sums are lost.
- Full-rate timeline (start seen in IDLE at cycle 0, in_valid and out_ready held 1):
  - busy=1 from cycle 1.
  - Accepts occur at cycles 1..K.
  - FLUSH spans cycles K+1..K+ROWS+COLS-1.
  - Row 0 appears with out_valid=1 at cycle K+ROWS+COLS.
  - Row r appears at K+ROWS+COLS+r.
  - done=1 and busy=0 at cycle K+2*ROWS+COLS.
- k_len=0: DRAIN starts at cycle 1 and done is at cycle ROWS+1.
- Output handshake: out_valid, out_row, out_data and out_last hold stable while out_valid=1 and out_ready=0. out_ready while out_valid=0 has no effect.
- out_data is registered from the accumulators; there is no combinational path from in_* to out_*.

## Test plan
- Reset: drive rst for 2 cycles mid-COMPUTE -> all outputs read 0 the next cycle; a following tile with accumulate=1 and K=1 (a=1, w=1) gives every sum = 1.
- Identity load, 8x8, K=8:
  - Stimulus: a[n]_i = (i==n), w[n]_j = 8n+j+1.
  - Response: C[i][j] = 8i+j+1; first out_valid at cycle 24; done at cycle 32; out_last only on row 7.
- Signed extremes, K=1:
  - a = w = -32768 on all lanes -> every sum = 1073741824.
  - Then accumulate=0, a=-1, w=32767 -> every sum = -32767 (36-bit two's complement 0xFFFFF8001).
- Backpressure and bubbles:
  - Stimulus: repeat the identity-load stimulus with in_valid toggled 1,0,0,1..., and out_ready held 0 for 3 cycles at row 2.
  - Response: results match the identity test; out_data and out_row stay stable while stalled; done follows row 7 acceptance by 1 cycle.
- Accumulate mode: identity load, then the same tile with accumulate=1 -> C[i][j] = 2*(8i+j+1); then start with k_len=0, accumulate=0 -> 8 rows of zeros, done at cycle 9.
- Ignored start and parameter sweep: pulse start during COMPUTE -> no effect on k_len or result. Repeat the identity-style test at ROWS=4, COLS=6, DATA_W=8, ACC_W=20 with K=4 -> C[i][j] = w[i]_j, first out_valid at cycle 14.
